// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_DONE,
    ST_RELEASE
  } arb_state_e;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of the shared UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = uart_pkg::DEFAULT_DATA_W,
  parameter int GRANT_W = uart_pkg::grant_w(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic [GRANT_W-1:0]        grant_id;
  logic                      busy;
  logic                      timeout_err;

  modport slave (
    input  req_valid, req_data, req_lock, tx_done,
    output req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );

  modport master (
    output req_valid, req_data, req_lock, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after last_grant+1, wrapping.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_grant_i,
  output logic [GRANT_W-1:0] idx_o,
  output logic               any_o
);

  logic               found;
  logic [GRANT_W-1:0] cand;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GRANT_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ requesters with round-robin
// arbitration, optional ownership lock, and a tx_start-to-tx_done watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int LOCK_MAX    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int GRANT_W = grant_w(NUM_REQ);
  localparam int WDOG_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int LCNT_W  = $clog2(LOCK_MAX) + 1;

  arb_state_e         state_q;
  logic [GRANT_W-1:0] grant_id_q;
  logic [GRANT_W-1:0] last_grant_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic               lock_q;
  logic [LCNT_W-1:0]  lock_cnt_q;
  logic [LCNT_W-1:0]  lock_cnt_d;
  logic [WDOG_W-1:0]  wdog_q;
  logic [WDOG_W-1:0]  wdog_d;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               timeout_err_q;

  logic [GRANT_W-1:0] pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  pick_data;
  logic [DATA_W-1:0]  own_data;
  logic               relock_ok;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_picker (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .idx_o        (pick_idx),
    .any_o        (pick_any)
  );

  always_comb begin
    pick_data = '0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT_W'(i) == pick_idx) pick_data = bus.req_data[i*DATA_W +: DATA_W];
      if (GRANT_W'(i) == grant_id_q) own_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GRANT_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign wdog_d     = wdog_q + WDOG_W'(1);
  assign lock_cnt_d = lock_cnt_q + LCNT_W'(1);
  assign relock_ok  = lock_q && (lock_cnt_q < LCNT_W'(LOCK_MAX - 1)) &&
                      bus.req_valid[grant_id_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= GRANT_W'(NUM_REQ - 1);
      tx_data_q     <= '0;
      lock_q        <= 1'b0;
      lock_cnt_q    <= '0;
      wdog_q        <= '0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id_q   <= pick_idx;
            last_grant_q <= pick_idx;
            tx_data_q    <= pick_data;
            lock_q       <= bus.req_lock[pick_idx];
            req_ready_q  <= onehot(pick_idx);
            tx_start_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          wdog_q  <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          wdog_q <= wdog_d;
          if (bus.tx_done) begin
            state_q <= ST_RELEASE;
          // Abort as the watchdog steps onto TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles after tx_start.
          end else if (wdog_q == WDOG_W'(TIMEOUT_CYC - 2)) begin
            timeout_err_q <= 1'b1;
            lock_q        <= 1'b0;
            lock_cnt_q    <= '0;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          if (relock_ok) begin
            tx_data_q   <= own_data;
            lock_q      <= bus.req_lock[grant_id_q];
            lock_cnt_q  <= lock_cnt_d;
            req_ready_q <= onehot(grant_id_q);
            tx_start_q  <= 1'b1;
            state_q     <= ST_GRANT;
          end else begin
            lock_cnt_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a transmitter model
// answering tx_start with tx_done, and a monitor popping expected grants.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int LOCK_MAX    = 16;
  localparam int TIMEOUT_CYC = 4096;

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
  } grantT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   doneDelay = 2;
  bit   dropDone = 1'b0;
  bit   timeoutAllowed = 1'b0;

  grantT             expQ[$];
  logic [DATA_W-1:0] reqDataQ [NUM_REQ][$];
  logic              reqLockQ [NUM_REQ][$];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) arbIf ();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .LOCK_MAX    (LOCK_MAX),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (arbIf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic driveReqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqDataQ[i].size() > 0) begin
        arbIf.req_valid[i] = 1'b1;
        arbIf.req_data[i*DATA_W +: DATA_W] = reqDataQ[i][0];
        arbIf.req_lock[i] = reqLockQ[i][0];
      end else begin
        arbIf.req_valid[i] = 1'b0;
        arbIf.req_lock[i] = 1'b0;
      end
    end
  endtask

  function automatic int pendingReqs();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += reqDataQ[i].size();
    return n;
  endfunction

  task automatic applyStimulus(input int id, input logic [DATA_W-1:0] data, input logic lock);
    reqDataQ[id].push_back(data);
    reqLockQ[id].push_back(lock);
    driveReqs();
  endtask

  task automatic expectGrant(input int id, input logic [DATA_W-1:0] data);
    grantT g;
    g.id = id;
    g.data = data;
    expQ.push_back(g);
  endtask

  task automatic clearQueues();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqDataQ[i].delete();
      reqLockQ[i].delete();
    end
    expQ.delete();
    driveReqs();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    clearQueues();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic waitTxStart(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!arbIf.tx_start && n < 64);
    checkOutput({tag, "_tx_start_seen"}, 32'(arbIf.tx_start), 1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((arbIf.busy || expQ.size() != 0 || pendingReqs() != 0) && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({tag, "_drain"}, 32'(expQ.size() + pendingReqs()), 0);
    checkOutput({tag, "_idle"}, 32'(arbIf.busy), 0);
  endtask

  // Transmitter model: answers each tx_start with a one-cycle tx_done doneDelay cycles later.
  always begin
    tick();
    if (arbIf.tx_start && !dropDone && !rst) begin
      repeat (doneDelay) @(posedge clk);
      #1 arbIf.tx_done = 1'b1;
      @(posedge clk);
      #1 arbIf.tx_done = 1'b0;
    end
  end

  always begin
    tick();
    if (!rst) begin
      if (arbIf.tx_start || (arbIf.req_ready != '0)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_grant", 32'({arbIf.tx_start, arbIf.req_ready}), 0);
        end else begin
          grantT e;
          e = expQ.pop_front();
          checkOutput("grant_id", 32'(arbIf.grant_id), 32'(e.id));
          checkOutput("tx_data", 32'(arbIf.tx_data), 32'(e.data));
          checkOutput("req_ready_onehot", 32'(arbIf.req_ready), 32'(1) << e.id);
          checkOutput("tx_start_with_ready", 32'(arbIf.tx_start), 1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (arbIf.req_ready[i] && reqDataQ[i].size() > 0) begin
            void'(reqDataQ[i].pop_front());
            void'(reqLockQ[i].pop_front());
          end
        end
        driveReqs();
      end
      if (arbIf.timeout_err) checkOutput("timeout_err_allowed", 32'(arbIf.timeout_err), 32'(timeoutAllowed));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    arbIf.req_valid = '0;
    arbIf.req_data  = '0;
    arbIf.req_lock  = '0;
    arbIf.tx_done   = 1'b0;

    rst = 1'b1;
    clearQueues();
    repeat (3) tick();
    checkOutput("rst_busy", 32'(arbIf.busy), 0);
    checkOutput("rst_tx_start", 32'(arbIf.tx_start), 0);
    checkOutput("rst_req_ready", 32'(arbIf.req_ready), 0);
    checkOutput("rst_grant_id", 32'(arbIf.grant_id), 0);
    checkOutput("rst_tx_data", 32'(arbIf.tx_data), 0);
    checkOutput("rst_timeout_err", 32'(arbIf.timeout_err), 0);
    rst = 1'b0;

    // Single requester: one-cycle latency, busy drops two cycles after tx_done.
    doneDelay = 20;
    expectGrant(2, 8'h41);
    applyStimulus(2, 8'h41, 1'b0);
    tick();
    checkOutput("t1_tx_start_latency", 32'(arbIf.tx_start), 1);
    checkOutput("t1_req_ready", 32'(arbIf.req_ready), 32'h4);
    repeat (21) tick();
    checkOutput("t1_busy_in_release", 32'(arbIf.busy), 1);
    tick();
    checkOutput("t1_busy_fall", 32'(arbIf.busy), 0);
    waitIdle("t1");

    // All four valid, no lock: plain rotation starting at requester 0.
    applyReset();
    doneDelay = 2;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        logic [DATA_W-1:0] d;
        d = DATA_W'(32 + 16 * i + k);
        expectGrant(i, d);
        applyStimulus(i, d, 1'b0);
      end
    end
    waitIdle("t2");

    // Requester 1 locks three bytes while requester 0 waits.
    expectGrant(1, 8'h10);
    expectGrant(1, 8'h11);
    expectGrant(1, 8'h12);
    expectGrant(0, 8'h0A);
    applyStimulus(1, 8'h10, 1'b1);
    applyStimulus(1, 8'h11, 1'b1);
    applyStimulus(1, 8'h12, 1'b0);
    waitTxStart("t3");
    applyStimulus(0, 8'h0A, 1'b0);
    waitIdle("t3");

    // Requester 3 streams under lock: forced release after LOCK_MAX bytes.
    for (int k = 0; k < LOCK_MAX + 1; k++) applyStimulus(3, DATA_W'(8'h80 + k), 1'b1);
    for (int k = 0; k < LOCK_MAX; k++) expectGrant(3, DATA_W'(8'h80 + k));
    expectGrant(0, 8'hB0);
    expectGrant(3, DATA_W'(8'h80 + LOCK_MAX));
    waitTxStart("t4");
    applyStimulus(0, 8'hB0, 1'b0);
    waitIdle("t4");

    // Watchdog: no tx_done, abort after TIMEOUT_CYC cycles, then normal grant.
    dropDone = 1'b1;
    timeoutAllowed = 1'b1;
    expectGrant(1, 8'h55);
    applyStimulus(1, 8'h55, 1'b0);
    waitTxStart("t5");
    n = 0;
    do begin
      tick();
      n++;
    end while (!arbIf.timeout_err && n < TIMEOUT_CYC + 16);
    checkOutput("t5_timeout_cycles", 32'(n), TIMEOUT_CYC);
    checkOutput("t5_timeout_busy", 32'(arbIf.busy), 0);
    tick();
    checkOutput("t5_timeout_pulse_width", 32'(arbIf.timeout_err), 0);
    timeoutAllowed = 1'b0;
    dropDone = 1'b0;
    expectGrant(2, 8'h66);
    applyStimulus(2, 8'h66, 1'b0);
    waitIdle("t5");

    // Reset during WAIT_DONE, then first grant must go to requester 0.
    dropDone = 1'b1;
    expectGrant(2, 8'h77);
    applyStimulus(2, 8'h77, 1'b0);
    waitTxStart("t6");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checkOutput("t6_rst_busy", 32'(arbIf.busy), 0);
    checkOutput("t6_rst_tx_start", 32'(arbIf.tx_start), 0);
    checkOutput("t6_rst_req_ready", 32'(arbIf.req_ready), 0);
    clearQueues();
    tick();
    rst = 1'b0;
    dropDone = 1'b0;
    expectGrant(0, 8'hA0);
    expectGrant(3, 8'hA3);
    applyStimulus(3, 8'hA3, 1'b0);
    applyStimulus(0, 8'hA0, 1'b0);
    waitIdle("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter among NUM_REQ requesters, e.g. CPU store path, debug monitor and loopback echo of received bytes.
- Arbitration is round-robin, with an optional lock that keeps ownership for multi-byte messages.
- Sequences the transmitter with a start/done handshake and a watchdog.
- Sits between the requesters and the UART TX datapath, in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
LOCK_MAX, 16, maximum consecutive bytes one requester may hold under lock
TIMEOUT_CYC, 4096, cycles allowed from tx_start to tx_done before abort

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i uses slice [i*DATA_W +: DATA_W]
req_lock  input  NUM_REQ  keep ownership after the current byte
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse
tx_start  output  1  one-cycle pulse to the transmitter
tx_data  output  DATA_W  byte to transmit; held stable from tx_start until tx_done
tx_done  input  1  one-cycle pulse from the transmitter at end of stop bit
grant_id  output  $clog2(NUM_REQ)  current or last owner
busy  output  1  high in any state except IDLE
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, last_grant=NUM_REQ-1 (so requester 0 wins first), lock counter 0, watchdog 0.
- All outputs are registered.
- States: IDLE, GRANT, WAIT_DONE, RELEASE.
- IDLE:
  - If any req_valid is set, select the first set index at or after (last_grant+1) mod NUM_REQ, wrapping.
  - Latch the index into grant_id/last_grant, latch the byte into tx_data, latch the req_lock bit. Go to GRANT.
  - If no req_valid is set, stay in IDLE.
- GRANT (exactly one cycle):
  - req_ready[grant_id]=1 and tx_start=1.
  - Watchdog clears to 0. Go to WAIT_DONE.
- Latency: req_valid high in IDLE at cycle N gives req_ready and tx_start at cycle N+1.
- Requester rule: req_data and req_valid must stay stable until req_ready. A byte is consumed only on req_ready.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - On tx_done, go to RELEASE.
  - If the watchdog reaches TIMEOUT_CYC-1 without tx_done: pulse timeout_err, clear lock, go to IDLE. The byte is lost; the requester is not retried.
  - tx_done outside WAIT_DONE is ignored.
- RELEASE (one cycle):
  - If the latched lock is 1, lock count < LOCK_MAX-1, and req_valid[grant_id]=1: re-latch req_data and req_lock of the same requester, lock count +1, go to GRANT without arbitration.
  - Otherwise: lock count=0, go to IDLE. A locked owner that drops req_valid loses the lock.
- Back-to-back bytes from one locked owner: minimum gap of 2 cycles from tx_done to the next tx_start.
- Forced release: after LOCK_MAX consecutive bytes the lock is released and arbitration resumes from grant_id+1.
- Requests arriving in the same cycle are resolved only by round-robin order; there is no fixed priority.
- A reset mid-transfer returns to IDLE immediately with outputs cleared. The in-flight byte is not reported.
- tx_data stays unchanged from tx_start until the next GRANT.

Decomposition:
- Package uart_pkg:
  - state enum for this block;
  - DATA_W default;
  - GRANT_W = $clog2(NUM_REQ) helper.
- Sub-module rr_picker: combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: index, any.
  - Instantiated once; reusable by other shared resources.

Test Plan:
- Single requester: req_valid[2]=1, data 0x41, tx_done 20 cycles after tx_start -> req_ready=4'b0100 and tx_start one cycle after request, tx_data=0x41, grant_id=2, busy falls 2 cycles after tx_done.
- All four valid continuously, no lock -> grant order 0,1,2,3,0; each req_ready one-hot and exactly one per tx_done.
- Requester 1 with lock=1 for 3 bytes (0x10,0x11,0x12) while requester 0 also valid -> three consecutive grants to 1, then grant to 0.
- Lock held with LOCK_MAX=16 and requester 3 streaming, requester 0 valid -> 16 bytes to 3, then grant_id=0.
- tx_done never arrives -> timeout_err pulses TIMEOUT_CYC cycles after tx_start, state returns to IDLE, next requester is granted normally.
- rst asserted during WAIT_DONE -> next cycle busy=0, tx_start=0, req_ready=0; first grant after reset goes to requester 0.
